// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle ARM-subset core sequencer.
// Contents: sequencer state enum, instruction class codes, never-execute condition code.
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StDecode = 2'd2,
        StExec   = 2'd3
    } state_e;

    // Instruction class, taken from instr[27:26]
    localparam logic [1:0] CLS_DP = 2'b00;  // data processing
    localparam logic [1:0] CLS_LS = 2'b01;  // load/store
    localparam logic [1:0] CLS_BR = 2'b10;  // branch / branch-with-link
    localparam logic [1:0] CLS_CP = 2'b11;  // coprocessor / SWI

    // Condition field value for an instruction that is never executed
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/instr_sequencer_if.sv
// Memory request bus between the sequencer and the memory system.
// master: drives mem_req, mem_we, mem_addr; samples mem_ready, mem_rdata.
// slave:  the memory side of the same handshake.
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/instr_classify.sv
// Combinational instruction decoder for the sequencer.
// Ports:
//   instr      in   latched 32-bit instruction
//   cls        out  instruction class (instr[27:26])
//   skip       out  condition field is never-execute
//   num_steps  out  number of EXEC steps for this instruction (1 or 2)
//   load       out  L bit of a load/store
//   link       out  link bit of a branch
//   br_offset  out  sign-extended word offset of a branch, in bytes
module instr_classify
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [31:0]       instr,
    output logic [1:0]        cls,
    output logic              skip,
    output logic [1:0]        num_steps,
    output logic              load,
    output logic              link,
    output logic [ADDR_W-1:0] br_offset
);
    // Immediate/register-form bit is irrelevant to sequencing
    logic unused_instr;
    assign unused_instr = instr[25];

    always_comb begin
        cls       = instr[27:26];
        skip      = (instr[31:28] == COND_NV);
        load      = instr[20];
        link      = instr[24];
        num_steps = (cls == CLS_LS && load) ? 2'd2 : 2'd1;
        // Size cast of a signed operand sign-extends (or wraps) to the PC width
        br_offset = ADDR_W'($signed({instr[23:0], 2'b00}));
    end
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, fetches over a ready handshake,
// runs a per-class number of EXEC steps and decodes one-hot control strobes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          memory request bus (master side)
//   alu_addr     load/store effective address from the datapath
//   instr        latched instruction register
//   pc           current program counter (already advanced past the fetched instruction)
//   exec_step    step index within EXEC
//   reg_we       register-bank write strobe
//   link_we      R14 link write strobe (same cycle as the branch PC update)
//   undef        undefined/coprocessor-class pulse
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 32,
    parameter int unsigned     DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_sequencer_if.master   bus,
    input  logic [ADDR_W-1:0]   alu_addr,
    output logic [DATA_W-1:0]   instr,
    output logic [ADDR_W-1:0]   pc,
    output logic [1:0]          exec_step,
    output logic                reg_we,
    output logic                link_we,
    output logic                undef
);
    state_e            state;
    logic [1:0]        cls;
    logic              skip;
    logic [1:0]        num_steps;
    logic [1:0]        last_step;
    logic              load;
    logic              link;
    logic [ADDR_W-1:0] br_offset;
    logic              ls_access;

    instr_classify #(
        .ADDR_W (ADDR_W)
    ) u_classify (
        .instr     (instr[31:0]),
        .cls       (cls),
        .skip      (skip),
        .num_steps (num_steps),
        .load      (load),
        .link      (link),
        .br_offset (br_offset)
    );

    assign last_step = num_steps - 2'd1;
    // Only load/store step 0 talks to memory during EXEC
    assign ls_access = (state == StExec) && (cls == CLS_LS) && (exec_step == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            pc        <= RESET_PC;
            instr     <= '0;
            exec_step <= '0;
        end else begin
            case (state)
                StIdle: state <= StFetch;
                StFetch: begin
                    if (bus.mem_ready) begin
                        instr <= DATA_W'(bus.mem_rdata[31:0]);
                        pc    <= pc + PC_STEP;
                        state <= StDecode;
                    end
                end
                StDecode: begin
                    exec_step <= '0;
                    state     <= skip ? StFetch : StExec;
                end
                StExec: begin
                    // Load/store step 0 stalls until memory completes
                    if (!(ls_access && !bus.mem_ready)) begin
                        // pc already points past this instruction, hence one more PC_STEP
                        if (cls == CLS_BR && exec_step == 2'd0) begin
                            pc <= pc + PC_STEP + br_offset;
                        end
                        if (exec_step == last_step) begin
                            exec_step <= '0;
                            state     <= StFetch;
                        end else begin
                            exec_step <= exec_step + 2'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Moore strobes decoded from the registered state, step and latched instruction
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        reg_we       = 1'b0;
        link_we      = 1'b0;
        undef        = 1'b0;
        if (state == StFetch) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc;
        end else if (state == StExec) begin
            bus.mem_addr = alu_addr;
            bus.mem_req  = ls_access;
            bus.mem_we   = ls_access && !load;
            reg_we       = (cls == CLS_DP && exec_step == 2'd0) ||
                           (cls == CLS_LS && load && exec_step == 2'd1);
            link_we      = (cls == CLS_BR && exec_step == 2'd0) && link;
            undef        = (cls == CLS_CP && exec_step == 2'd0);
        end
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Parametrised fetch/decode/execute sequencer for the multi-cycle ARM-subset CPU core.
- Replaces the fixed eight-step control counter with a per-class step count.
- Owns the program counter and waits on memory through a ready handshake.
- Computes branch targets and drives the one-hot control strobes consumed by the address register, register bank and memory.

## Interface
- `ADDR_W`, 32, width of PC and memory address
- `DATA_W`, 32, instruction/memory data width (≥32)
- `RESET_PC`, 0, PC value loaded on reset
- `PC_STEP`, 4, PC increment per fetched instruction
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_ready`  in  1  memory has completed the current request this cycle
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ready`=1
- `alu_addr`  in  ADDR_W  load/store effective address from datapath
- `mem_req`  out  1  memory request
- `mem_we`  out  1  request is a write
- `mem_addr`  out  ADDR_W  PC in FETCH, `alu_addr` in EXEC, 0 otherwise
- `instr`  out  DATA_W  latched instruction register
- `pc`  out  ADDR_W  current PC
- `exec_step`  out  2  step index within EXEC
- `reg_we`, `link_we`, `undef`  out  1 each  register-bank write, R14 link write, undefined-class pulse

## Operation
- States: IDLE, FETCH, DECODE, EXEC.
- Reset asynchronously forces:
  - state=IDLE, pc=`RESET_PC`, instr=0, exec_step=0
  - all strobes 0, mem_addr=0
- IDLE → FETCH unconditionally on the next edge.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - Holds while mem_ready=0.
  - On an edge with mem_ready=1: instr←mem_rdata[31:0], pc←pc+PC_STEP, → DECODE.
- DECODE: one cycle, no strobes. Class = instr[27:26]:
  - cond instr[31:28]=4'hF: → FETCH (instruction skipped).
  - 00 data-processing: 1 EXEC step.
  - 01 load/store: L=instr[20]; store 1 step, load 2 steps.
  - 10 branch: 1 step; target = pc + PC_STEP + (sign-extended instr[23:0] << 2), computed modulo 2^ADDR_W.
  - 11 coprocessor/SWI: 1 step.
- EXEC per class (exec_step starts at 0):
  - DP step0: reg_we=1.
  - LS step0: mem_req=1, mem_we=~L, mem_addr=alu_addr; holds until mem_ready. Load step1: reg_we=1.
  - Branch step0: pc←target; link_we=instr[24].
  - Class 11 step0: undef=1.
- After the last step, → FETCH and exec_step←0.
- Strobes are Moore outputs decoded from state/step/class; each is a one-cycle pulse unless it is held by a mem_ready wait.

## Timing
- Minimum instruction latency with zero-wait memory:
  - FETCH 1, DECODE 1, EXEC n cycles.
  - DP/branch/store: 3 cycles. Load: 4 cycles. Skipped cond=F: 2 cycles.
- Each cycle with mem_ready=0 in FETCH or LS step0 adds exactly one cycle. No other state advances.
- `link_we` is asserted in the same cycle as the pc update. The link value is pc before the load, i.e. the address of the next instruction.
- mem_ready while mem_req=0 is ignored.
- PC wraps modulo 2^ADDR_W; no fault is raised.
- rst_n asserted mid-wait drops mem_req in the same cycle (asynchronous). The pending request is abandoned.
- First FETCH request appears on the second rising edge after rst_n deasserts.

## Structure
- Shared `cpu_pkg`:
  - state enum
  - class codes (CLS_DP, CLS_LS, CLS_BR, CLS_CP)
  - COND_NV=4'hF
- Sub-module `instr_classify` (combinational): instr → class, step count, L bit, link bit, branch offset.
- The FSM, PC and step counter stay in `instr_sequencer`.

## Test plan
- Reset: rst_n=0 → mem_req=0, pc=0, state IDLE. Release → mem_req=1 with mem_addr=0 on the second edge.
- DP fetch, zero-wait: mem_rdata=32'hE0811002 → reg_we pulse 2 cycles after the fetch edge; next fetch at addr 4.
- Load with waits: instr 32'hE5912000, alu_addr=32'h40, mem_ready low 2 cycles in EXEC → mem_addr=32'h40 held 3 cycles, then reg_we, then fetch at pc+4. Total 6 cycles.
- Branch: pc=8, instr 32'hEBFFFFFE (BL, offset −2) → pc becomes 8 and link_we=1 in EXEC; next mem_addr=8.
- cond=F (32'hF0000000) and class 11 (32'hEF000000): first refetches after 2 cycles with no strobes; second pulses undef once.
- Async reset while FETCH is stalled with mem_ready=0 → mem_req falls immediately; pc=RESET_PC; no strobe glitch.
